// File: rtl/dmi_resp_slave.sv
// Core-side DMI responder with a small lock-gated debug register window.
// Optional lock-failure counter at 0x12 enabled by defining DMI_RESP_FAILCNT_EN.
module dmi_resp_slave #(
  parameter int         NumData       = 4,
  parameter int         AccessLatency = 2,
  parameter logic [3:0] Version       = 4'h2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [40:0] dmi_req_i,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  output logic [33:0] dmi_resp_o,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  input  logic        unlock_i,
  output logic [1:0]  ctrl_o
);

  if (AccessLatency < 1 || AccessLatency > 15) begin : gBadLatency
    $error("dmi_resp_slave: AccessLatency must be in 1..15");
  end
  if (NumData < 1 || NumData > 12) begin : gBadNumData
    $error("dmi_resp_slave: NumData must be in 1..12");
  end

  localparam logic [6:0] AddrData0  = 7'h04;
  localparam logic [6:0] AddrCtrl   = 7'h10;
  localparam logic [6:0] AddrStatus = 7'h11;
  localparam logic [6:0] AddrFail   = 7'h12;

  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;
  localparam logic [1:0] RespFailed = 2'd2;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [6:0]  r_addr;
  logic [1:0]  r_op;
  logic [31:0] r_wdata;
  logic [31:0] r_data [NumData];
  logic [1:0]  r_ctrl;
  logic        r_reqReady;
  logic        r_respValid;
  logic [33:0] r_resp;
`ifdef DMI_RESP_FAILCNT_EN
  logic [15:0] r_failCnt;
`endif

  logic [6:0]  w_dataIdx;
  logic        w_isData;
  logic [31:0] w_dataRd;
  logic [31:0] w_regRd;
  logic        w_readOpen;
  logic [31:0] w_respData;
  logic [1:0]  w_respCode;
  logic        w_wrData;
  logic        w_wrCtrl;
  logic        w_clrFail;
  logic        w_lockFail;

  assign dmi_req_ready_o  = r_reqReady;
  assign dmi_resp_valid_o = r_respValid;
  assign dmi_resp_o       = r_resp;
  assign ctrl_o           = r_ctrl;

  assign w_dataIdx = r_addr - AddrData0;
  assign w_isData  = (r_addr >= AddrData0) && (w_dataIdx < 7'(NumData));

  // Access decode for the latched request; unlock_i is used live so the
  // lock state seen is the one in the execute cycle.
  always_comb begin
    w_dataRd   = '0;
    w_regRd    = '0;
    w_readOpen = 1'b0;
    w_respData = '0;
    w_respCode = '0;
    w_wrData   = 1'b0;
    w_wrCtrl   = 1'b0;
    w_clrFail  = 1'b0;
    w_lockFail = 1'b0;

    for (int i = 0; i < NumData; i++) begin
      if (w_dataIdx == 7'(i)) w_dataRd = r_data[i];
    end

    if (w_isData)                 w_regRd = w_dataRd;
    else if (r_addr == AddrCtrl)   w_regRd = {30'b0, r_ctrl};
    else if (r_addr == AddrStatus) w_regRd = {27'b0, unlock_i, Version};
`ifdef DMI_RESP_FAILCNT_EN
    else if (r_addr == AddrFail)   w_regRd = {16'b0, r_failCnt};
`endif

`ifdef DMI_RESP_FAILCNT_EN
    w_readOpen = unlock_i || (r_addr == AddrStatus) || (r_addr == AddrFail);
`else
    w_readOpen = unlock_i || (r_addr == AddrStatus);
`endif

    case (r_op)
      OpRead: begin
        if (w_readOpen) begin
          w_respData = w_regRd;
        end else begin
          w_respCode = RespFailed;
          w_lockFail = 1'b1;
        end
      end
      OpWrite: begin
        if (unlock_i) begin
          w_respData = r_wdata;
          if (w_isData) begin
            w_wrData = 1'b1;
          end else if (r_addr == AddrCtrl) begin
            w_wrCtrl   = 1'b1;
            w_respData = {30'b0, r_wdata[1:0]};
          end else if (r_addr == AddrFail) begin
            w_clrFail = 1'b1;
          end
        end else begin
          w_respCode = RespFailed;
          w_lockFail = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Single-outstanding FSM; a request arriving while busy waits upstream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_op        <= '0;
      r_wdata     <= '0;
      r_ctrl      <= '0;
      r_reqReady  <= 1'b1;
      r_respValid <= 1'b0;
      r_resp      <= '0;
      for (int i = 0; i < NumData; i++) r_data[i] <= '0;
`ifdef DMI_RESP_FAILCNT_EN
      r_failCnt   <= '0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (dmi_req_valid_i && r_reqReady) begin
            r_addr     <= dmi_req_i[40:34];
            r_op       <= dmi_req_i[33:32];
            r_wdata    <= dmi_req_i[31:0];
            r_cnt      <= 4'(AccessLatency - 1);
            r_reqReady <= 1'b0;
            r_state    <= StAccess;
          end
        end
        StAccess: begin
          if (r_cnt == 4'd0) begin
            r_resp      <= {w_respData, w_respCode};
            r_respValid <= 1'b1;
            r_state     <= StResp;
            if (w_wrCtrl) r_ctrl <= r_wdata[1:0];
            for (int i = 0; i < NumData; i++) begin
              if (w_wrData && (w_dataIdx == 7'(i))) r_data[i] <= r_wdata;
            end
`ifdef DMI_RESP_FAILCNT_EN
            if (w_lockFail && (r_failCnt != 16'hFFFF)) r_failCnt <= r_failCnt + 16'd1;
            else if (w_clrFail)                         r_failCnt <= '0;
`endif
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StResp: begin
          if (dmi_resp_ready_i) begin
            r_respValid <= 1'b0;
            r_reqReady  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
